// File: rtl/l3_dispatch_ctrl.sv
// l3_dispatch_ctrl: per-frame sequencer between the EtherType classifier and the
// IPv4/IPv6/ARP header parsers. Opens a frame context on i_frame_start, waits for a
// classifier verdict, starts exactly one parser, waits for its done, then clears the
// classifier's sticky result. Unknown/ambiguous verdicts are dropped; a watchdog aborts
// frames that stall.
// Ports:
//   clk, rst_n                    clock (posedge), asynchronous active-low reset
//   i_frame_start                 pulse: new frame header parse begins
//   i_proto_valid, i_is_*         sticky classifier verdict and flags
//   o_ipv4/ipv6/arp_start         1-cycle parser start pulses
//   i_ipv4/ipv6/arp_done          parser completion inputs
//   o_cls_clr                     1-cycle pulse: clear classifier verdict
//   o_busy                        frame context open
//   o_frame_done/drop/timeout     1-cycle end-of-frame outcome pulses
//   o_frame_overrun               1-cycle pulse: frame_start ignored while busy
//   o_done_cnt/drop_cnt/tmo_cnt   saturating outcome counters
// All outputs are driven directly from flops.
module l3_dispatch_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_start,
  input  logic             i_proto_valid,
  input  logic             i_is_ipv4,
  input  logic             i_is_ipv6,
  input  logic             i_is_arp,
  input  logic             i_is_unknown,
  output logic             o_ipv4_start,
  output logic             o_ipv6_start,
  output logic             o_arp_start,
  input  logic             i_ipv4_done,
  input  logic             i_ipv6_done,
  input  logic             i_arp_done,
  output logic             o_cls_clr,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_frame_drop,
  output logic             o_frame_timeout,
  output logic             o_frame_overrun,
  output logic [CNT_W-1:0] o_done_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_tmo_cnt
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CLS, S_WAIT_DONE, S_FINISH} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_IPV4, SEL_IPV6, SEL_ARP} sel_t;

  state_t          r_state, w_state_nxt;
  sel_t            r_sel, w_sel_nxt;
  logic [WD_W-1:0] r_wd;

  logic w_cls_ok, w_wd_exp, w_sel_done, w_wd_clr;
  logic w_v4s, w_v6s, w_arps, w_done, w_drop, w_tmo;

  // Verdict is usable only if exactly one known protocol flag is set.
  assign w_cls_ok = $onehot({i_is_ipv4, i_is_ipv6, i_is_arp}) && !i_is_unknown;
  assign w_wd_exp = (r_wd == WD_LAST);

  // Only the parser that was actually started may end the frame.
  always_comb begin
    w_sel_done = 1'b0;
    case (r_sel)
      SEL_IPV4: w_sel_done = i_ipv4_done;
      SEL_IPV6: w_sel_done = i_ipv6_done;
      SEL_ARP:  w_sel_done = i_arp_done;
      default:  w_sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next state plus the pulse values that get registered onto the outputs.
  // Qualifying events are tested before watchdog expiry so they win a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_wd_clr    = 1'b0;
    w_v4s       = 1'b0;
    w_v6s       = 1'b0;
    w_arps      = 1'b0;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) begin
          w_state_nxt = S_WAIT_CLS;
          w_wd_clr    = 1'b1;
        end
      end
      S_WAIT_CLS: begin
        if (i_proto_valid) begin
          if (w_cls_ok) begin
            w_state_nxt = S_WAIT_DONE;
            w_v4s       = i_is_ipv4;
            w_v6s       = i_is_ipv6;
            w_arps      = i_is_arp;
            if (i_is_ipv4)      w_sel_nxt = SEL_IPV4;
            else if (i_is_ipv6) w_sel_nxt = SEL_IPV6;
            else                w_sel_nxt = SEL_ARP;
          end else begin
            w_state_nxt = S_FINISH;
            w_drop      = 1'b1;
          end
        end else if (w_wd_exp) begin
          w_state_nxt = S_FINISH;
          w_tmo       = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (w_sel_done) begin
          w_state_nxt = S_FINISH;
          w_done      = 1'b1;
        end else if (w_wd_exp) begin
          w_state_nxt = S_FINISH;
          w_tmo       = 1'b1;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = SEL_NONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = SEL_NONE;
      end
    endcase
  end

  // Watchdog runs from frame accept; it holds at its last value so a verdict
  // arriving in the expiry cycle leaves the parser no further grace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (w_wd_clr) begin
      r_wd <= '0;
    end else if ((r_state == S_WAIT_CLS || r_state == S_WAIT_DONE) && !w_wd_exp) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ipv4_start    <= 1'b0;
      o_ipv6_start    <= 1'b0;
      o_arp_start     <= 1'b0;
      o_cls_clr       <= 1'b0;
      o_busy          <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_drop    <= 1'b0;
      o_frame_timeout <= 1'b0;
      o_frame_overrun <= 1'b0;
      o_done_cnt      <= '0;
      o_drop_cnt      <= '0;
      o_tmo_cnt       <= '0;
    end else begin
      o_ipv4_start    <= w_v4s;
      o_ipv6_start    <= w_v6s;
      o_arp_start     <= w_arps;
      o_cls_clr       <= w_done | w_drop | w_tmo;
      o_busy          <= (w_state_nxt != S_IDLE);
      o_frame_done    <= w_done;
      o_frame_drop    <= w_drop;
      o_frame_timeout <= w_tmo;
      o_frame_overrun <= i_frame_start && (r_state != S_IDLE);
      if (w_done && (o_done_cnt != '1)) o_done_cnt <= o_done_cnt + 1'b1;
      if (w_drop && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 1'b1;
      if (w_tmo  && (o_tmo_cnt  != '1)) o_tmo_cnt  <= o_tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_l3_dispatch_ctrl.sv
module tb_l3_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic use_b = 1'b0;
  logic fs = 0, pv = 0, v4 = 0, v6 = 0, arp = 0, unk = 0, d4 = 0, d6 = 0, da = 0;

  always #5 clk = ~clk;

  // Instance A: long watchdog, 16-bit counters. Instance B: 8-cycle watchdog, 2-bit counters.
  logic [8:0] in_vec, in_a, in_b;
  assign in_vec = {fs, pv, v4, v6, arp, unk, d4, d6, da};
  assign in_a   = use_b ? 9'd0 : in_vec;
  assign in_b   = use_b ? in_vec : 9'd0;

  logic        v4s_a, v6s_a, arps_a, clr_a, busy_a, done_a, drop_a, tmo_a, ovr_a;
  logic        v4s_b, v6s_b, arps_b, clr_b, busy_b, done_b, drop_b, tmo_b, ovr_b;
  logic [15:0] dcnt_a, rcnt_a, tcnt_a;
  logic [1:0]  dcnt_b, rcnt_b, tcnt_b;

  l3_dispatch_ctrl #(.TIMEOUT_CYCLES(1024), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_frame_start(in_a[8]), .i_proto_valid(in_a[7]), .i_is_ipv4(in_a[6]),
    .i_is_ipv6(in_a[5]), .i_is_arp(in_a[4]), .i_is_unknown(in_a[3]),
    .o_ipv4_start(v4s_a), .o_ipv6_start(v6s_a), .o_arp_start(arps_a),
    .i_ipv4_done(in_a[2]), .i_ipv6_done(in_a[1]), .i_arp_done(in_a[0]),
    .o_cls_clr(clr_a), .o_busy(busy_a), .o_frame_done(done_a), .o_frame_drop(drop_a),
    .o_frame_timeout(tmo_a), .o_frame_overrun(ovr_a),
    .o_done_cnt(dcnt_a), .o_drop_cnt(rcnt_a), .o_tmo_cnt(tcnt_a)
  );

  l3_dispatch_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_frame_start(in_b[8]), .i_proto_valid(in_b[7]), .i_is_ipv4(in_b[6]),
    .i_is_ipv6(in_b[5]), .i_is_arp(in_b[4]), .i_is_unknown(in_b[3]),
    .o_ipv4_start(v4s_b), .o_ipv6_start(v6s_b), .o_arp_start(arps_b),
    .i_ipv4_done(in_b[2]), .i_ipv6_done(in_b[1]), .i_arp_done(in_b[0]),
    .o_cls_clr(clr_b), .o_busy(busy_b), .o_frame_done(done_b), .o_frame_drop(drop_b),
    .o_frame_timeout(tmo_b), .o_frame_overrun(ovr_b),
    .o_done_cnt(dcnt_b), .o_drop_cnt(rcnt_b), .o_tmo_cnt(tcnt_b)
  );

  // Observed view of whichever instance is under test.
  logic [7:0]  pulses;
  logic        busy;
  logic [15:0] dcnt, rcnt, tcnt;
  assign pulses = use_b ? {v4s_b, v6s_b, arps_b, clr_b, done_b, drop_b, tmo_b, ovr_b}
                        : {v4s_a, v6s_a, arps_a, clr_a, done_a, drop_a, tmo_a, ovr_a};
  assign busy   = use_b ? busy_b : busy_a;
  assign dcnt   = use_b ? {14'd0, dcnt_b} : dcnt_a;
  assign rcnt   = use_b ? {14'd0, rcnt_b} : rcnt_a;
  assign tcnt   = use_b ? {14'd0, tcnt_b} : tcnt_a;

  localparam logic [7:0] P_V4S = 8'h80, P_V6S = 8'h40, P_ARPS = 8'h20, P_CLR = 8'h10;
  localparam logic [7:0] P_DONE = 8'h08, P_DROP = 8'h04, P_TMO = 8'h02, P_OVR = 8'h01;

  typedef struct packed {
    int         cyc;
    logic [7:0] p;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int base = 0;
  int total = 0;
  int bad = 0;

  task automatic expect_at(input int rel, input logic [7:0] p);
    exp_t e;
    e.cyc = base + rel;
    e.p   = p;
    sbq.push_back(e);
  endtask

  // Advance one clock; every cycle's pulse vector is checked against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    total++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      assert (pulses === e.p) else begin
        bad++;
        $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, pulses, e.p);
      end
    end else begin
      assert (pulses === 8'h00) else begin
        bad++;
        $error("FAIL stray_pulse cyc=%0d observed=%b expected=%b", cyc, pulses, 8'h00);
      end
    end
  endtask

  task automatic wait_rel(input int n);
    while (cyc < base + n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic start_frame();
    base = cyc;
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done_cnt", dcnt, 16'd0);
    chk("rst_drop_cnt", rcnt, 16'd0);
    chk("rst_tmo_cnt", tcnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // proto_valid while idle is ignored
    pv = 1; v4 = 1;
    tick(); tick();
    chk("idle_pv_busy", {15'd0, busy}, 16'd0);
    pv = 0; v4 = 0;
    tick();

    // IPv4 normal path
    start_frame();
    chk("v4_busy_rel1", {15'd0, busy}, 16'd1);
    wait_rel(3);
    pv = 1; v4 = 1;
    expect_at(4, P_V4S);
    tick();
    wait_rel(10);
    d4 = 1;
    expect_at(11, P_CLR | P_DONE);
    tick();
    d4 = 0; pv = 0; v4 = 0;
    chk("v4_busy_finish", {15'd0, busy}, 16'd1);
    tick();
    chk("v4_busy_rel12", {15'd0, busy}, 16'd0);
    chk("v4_done_cnt", dcnt, 16'd1);

    // Unknown -> drop
    start_frame();
    wait_rel(3);
    pv = 1; unk = 1;
    expect_at(4, P_CLR | P_DROP);
    tick();
    pv = 0; unk = 0;
    tick();
    chk("unk_busy", {15'd0, busy}, 16'd0);
    chk("unk_drop_cnt", rcnt, 16'd1);

    // Ambiguous ipv4+arp -> drop
    start_frame();
    wait_rel(3);
    pv = 1; v4 = 1; arp = 1;
    expect_at(4, P_CLR | P_DROP);
    tick();
    pv = 0; v4 = 0; arp = 0;
    tick();
    chk("amb_drop_cnt", rcnt, 16'd2);

    // IPv6 selected, wrong done inputs ignored
    start_frame();
    wait_rel(2);
    pv = 1; v6 = 1;
    expect_at(3, P_V6S);
    tick();
    pv = 0; v6 = 0;
    wait_rel(5);
    d4 = 1; da = 1;
    tick();
    d4 = 0; da = 0;
    wait_rel(8);
    chk("wrongdone_busy", {15'd0, busy}, 16'd1);
    wait_rel(9);
    d6 = 1;
    expect_at(10, P_CLR | P_DONE);
    tick();
    d6 = 0;
    tick();
    chk("wrongdone_busy_end", {15'd0, busy}, 16'd0);
    chk("wrongdone_done_cnt", dcnt, 16'd2);

    // frame_start while busy -> overrun, frame unaffected
    start_frame();
    wait_rel(3);
    pv = 1; arp = 1;
    expect_at(4, P_ARPS);
    tick();
    pv = 0; arp = 0;
    wait_rel(5);
    fs = 1;
    expect_at(6, P_OVR);
    tick();
    fs = 0;
    wait_rel(7);
    da = 1;
    expect_at(8, P_CLR | P_DONE);
    tick();
    da = 0;
    tick(); tick();
    chk("ovr_busy_after", {15'd0, busy}, 16'd0);
    chk("ovr_done_cnt", dcnt, 16'd3);

    // Back-to-back accept in first IDLE cycle; done coincident with start pulse
    start_frame();
    pv = 1; unk = 1;
    expect_at(2, P_CLR | P_DROP);
    tick();
    pv = 0; unk = 0;
    tick();
    fs = 1;
    tick();
    fs = 0;
    chk("b2b_busy", {15'd0, busy}, 16'd1);
    pv = 1; v4 = 1;
    expect_at(5, P_V4S);
    tick();
    pv = 0; v4 = 0; d4 = 1;
    expect_at(6, P_CLR | P_DONE);
    tick();
    d4 = 0;
    tick();
    chk("b2b_busy_end", {15'd0, busy}, 16'd0);
    chk("b2b_done_cnt", dcnt, 16'd4);
    chk("b2b_drop_cnt", rcnt, 16'd3);

    // Instance B: watchdog with no verdict
    use_b = 1'b1;
    tick();
    start_frame();
    expect_at(9, P_CLR | P_TMO);
    wait_rel(10);
    chk("wd_cls_busy", {15'd0, busy}, 16'd0);
    chk("wd_cls_tmo_cnt", tcnt, 16'd1);

    // Verdict in the expiry cycle wins; done coincident with start
    start_frame();
    wait_rel(8);
    pv = 1; v6 = 1;
    expect_at(9, P_V6S);
    tick();
    pv = 0; v6 = 0; d6 = 1;
    expect_at(10, P_CLR | P_DONE);
    tick();
    d6 = 0;
    tick();
    chk("wd_tie_done_cnt", dcnt, 16'd1);
    chk("wd_tie_tmo_cnt", tcnt, 16'd1);

    // ARP selected, done never arrives
    start_frame();
    wait_rel(2);
    pv = 1; arp = 1;
    expect_at(3, P_ARPS);
    tick();
    pv = 0; arp = 0;
    expect_at(9, P_CLR | P_TMO);
    wait_rel(10);
    chk("wd_arp_tmo_cnt", tcnt, 16'd2);
    chk("wd_arp_busy", {15'd0, busy}, 16'd0);

    // Saturation: five drops into a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      start_frame();
      pv = 1; unk = 1;
      expect_at(2, P_CLR | P_DROP);
      tick();
      pv = 0; unk = 0;
      tick();
    end
    chk("sat_drop_cnt", rcnt, 16'd3);

    // Instance A: reset asserted in WAIT_DONE
    use_b = 1'b0;
    tick();
    start_frame();
    wait_rel(2);
    pv = 1; v4 = 1;
    expect_at(3, P_V4S);
    tick();
    pv = 0; v4 = 0;
    tick();
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_pulses", {8'd0, pulses}, 16'd0);
    chk("midrst_done_cnt", dcnt, 16'd0);
    chk("midrst_drop_cnt", rcnt, 16'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("postrst_busy", {15'd0, busy}, 16'd0);

    chk("sb_empty", sbq.size() == 0 ? 16'd1 : 16'd0, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
